// File: rtl/ascon_seq_ctrl.sv
// Sequencing controller for an ASCON AEAD core: drives init, associated-data
// absorption, plaintext encryption and finalisation, with a completion timeout.
module ascon_seq_ctrl #(
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] ad_len_i,
  input  logic [LEN_W-1:0] pt_len_i,
  input  logic [127:0]     key_i,
  input  logic [127:0]     nonce_i,
  input  logic [63:0]      blk_data_i,
  input  logic             blk_valid_i,
  output logic             blk_ready_o,
  output logic             init_o,
  output logic             associate_data_o,
  output logic             finalisation_o,
  output logic             data_valid_o,
  output logic [63:0]      data_o,
  output logic [127:0]     key_o,
  output logic [127:0]     nonce_o,
  input  logic             end_initialisation_i,
  input  logic             end_associate_i,
  input  logic             end_cipher_i,
  input  logic             cipher_valid_i,
  input  logic             end_tag_i,
  input  logic [63:0]      cipher_i,
  input  logic [127:0]     tag_i,
  output logic [63:0]      out_data_o,
  output logic             out_valid_o,
  output logic [127:0]     tag_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int               TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ZERO  = TO_W'(0);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_WAIT_INIT = 4'd2,
    S_AD_FETCH  = 4'd3,
    S_AD_WAIT   = 4'd4,
    S_PT_FETCH  = 4'd5,
    S_PT_WAIT   = 4'd6,
    S_FIN_WAIT  = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [LEN_W-1:0] pt_cnt_q, pt_cnt_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     nonce_q, nonce_d;
  logic [63:0]      data_q, data_d;
  logic             dv_q, dv_d;
  logic             assoc_q, assoc_d;
  logic             fin_q, fin_d;
  logic             init_q, init_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [127:0]     tag_q, tag_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             xfer_s;
  logic             timeout_s;

  function automatic logic is_wait(input state_t s);
    return (s == S_WAIT_INIT) || (s == S_AD_WAIT) || (s == S_PT_WAIT) || (s == S_FIN_WAIT);
  endfunction

  // State and all output/latched registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ad_cnt_q    <= LEN_ZERO;
      pt_cnt_q    <= LEN_ZERO;
      key_q       <= 128'd0;
      nonce_q     <= 128'd0;
      data_q      <= 64'd0;
      dv_q        <= 1'b0;
      assoc_q     <= 1'b0;
      fin_q       <= 1'b0;
      init_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= 64'd0;
      out_valid_q <= 1'b0;
      tag_q       <= 128'd0;
      wait_cnt_q  <= TO_ZERO;
    end else begin
      state_q     <= state_d;
      ad_cnt_q    <= ad_cnt_d;
      pt_cnt_q    <= pt_cnt_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      assoc_q     <= assoc_d;
      fin_q       <= fin_d;
      init_q      <= init_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      tag_q       <= tag_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next-state, counters and next values of every registered output
  always_comb begin
    state_d     = state_q;
    ad_cnt_d    = ad_cnt_q;
    pt_cnt_d    = pt_cnt_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    data_d      = data_q;
    dv_d        = 1'b0;
    assoc_d     = 1'b0;
    fin_d       = 1'b0;
    err_d       = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    tag_d       = tag_q;
    xfer_s      = blk_valid_i && ready_q;
    timeout_s   = (wait_cnt_q == TO_LAST);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (pt_len_i != LEN_ZERO) begin
            ad_cnt_d = ad_len_i;
            pt_cnt_d = pt_len_i;
            key_d    = key_i;
            nonce_d  = nonce_i;
            state_d  = S_INIT;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        state_d = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (end_initialisation_i) begin
          state_d = (ad_cnt_q != LEN_ZERO) ? S_AD_FETCH : S_PT_FETCH;
        end else if (timeout_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT_INIT;
        end
      end
      S_AD_FETCH: begin
        if (xfer_s) begin
          data_d  = blk_data_i;
          dv_d    = 1'b1;
          assoc_d = 1'b1;
          state_d = S_AD_WAIT;
        end else begin
          state_d = S_AD_FETCH;
        end
      end
      S_AD_WAIT: begin
        if (end_associate_i) begin
          ad_cnt_d = ad_cnt_q - LEN_ONE;
          state_d  = (ad_cnt_q == LEN_ONE) ? S_PT_FETCH : S_AD_FETCH;
        end else if (timeout_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_AD_WAIT;
        end
      end
      S_PT_FETCH: begin
        if (xfer_s) begin
          data_d = blk_data_i;
          dv_d   = 1'b1;
          if (pt_cnt_q == LEN_ONE) begin
            fin_d   = 1'b1;
            state_d = S_FIN_WAIT;
          end else begin
            state_d = S_PT_WAIT;
          end
        end else begin
          state_d = S_PT_FETCH;
        end
      end
      S_PT_WAIT: begin
        if (end_cipher_i) begin
          pt_cnt_d = pt_cnt_q - LEN_ONE;
          state_d  = S_PT_FETCH;
        end else if (timeout_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_PT_WAIT;
        end
      end
      S_FIN_WAIT: begin
        if (end_tag_i) begin
          tag_d   = tag_i;
          state_d = S_DONE;
        end else if (timeout_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_FIN_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cipher blocks are only meaningful while plaintext is in flight
    if (cipher_valid_i && ((state_q == S_PT_WAIT) || (state_q == S_FIN_WAIT))) begin
      out_data_d  = cipher_i;
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end

    ready_d = (state_d == S_AD_FETCH) || (state_d == S_PT_FETCH);
    busy_d  = (state_d != S_IDLE);
    init_d  = (state_d == S_INIT);
    done_d  = (state_d == S_DONE);

    if ((state_d != state_q) || !is_wait(state_d)) begin
      wait_cnt_d = TO_ZERO;
    end else begin
      wait_cnt_d = wait_cnt_q + TO_ONE;
    end
  end

  assign blk_ready_o      = ready_q;
  assign init_o           = init_q;
  assign associate_data_o = assoc_q;
  assign finalisation_o   = fin_q;
  assign data_valid_o     = dv_q;
  assign data_o           = data_q;
  assign key_o            = key_q;
  assign nonce_o          = nonce_q;
  assign out_data_o       = out_data_q;
  assign out_valid_o      = out_valid_q;
  assign tag_o            = tag_q;
  assign done_o           = done_q;
  assign busy_o           = busy_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// Directed bench for ascon_seq_ctrl: table of whole transactions against a
// small ASCON core model, plus hand sequences for error, timeout and reset.
module tb_ascon_seq_ctrl;
  localparam int LEN_W   = 5;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset_i, start_i, blk_valid_i, blk_ready_o;
  logic [LEN_W-1:0] ad_len_i, pt_len_i;
  logic [127:0] key_i, nonce_i, key_o, nonce_o, tag_i, tag_o;
  logic [63:0] blk_data_i, data_o, cipher_i, out_data_o;
  logic init_o, associate_data_o, finalisation_o, data_valid_o;
  logic end_initialisation_i, end_associate_i, end_cipher_i, cipher_valid_i, end_tag_i;
  logic out_valid_o, done_o, busy_o, err_o;

  always #5 clk = ~clk;

  ascon_seq_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i),
    .ad_len_i(ad_len_i), .pt_len_i(pt_len_i), .key_i(key_i), .nonce_i(nonce_i),
    .blk_data_i(blk_data_i), .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .init_o(init_o), .associate_data_o(associate_data_o), .finalisation_o(finalisation_o),
    .data_valid_o(data_valid_o), .data_o(data_o), .key_o(key_o), .nonce_o(nonce_o),
    .end_initialisation_i(end_initialisation_i), .end_associate_i(end_associate_i),
    .end_cipher_i(end_cipher_i), .cipher_valid_i(cipher_valid_i), .end_tag_i(end_tag_i),
    .cipher_i(cipher_i), .tag_i(tag_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .tag_o(tag_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    int ad; int pt; int hold_idx; int hold_n;
    int exp_ad; int exp_pt; int exp_fin_at; int exp_ov; int exp_done;
  } vec_t;
  vec_t vecs[4];
  vec_t rst_vec;

  int n_checks = 0;
  int n_fail = 0;
  int init_cnt, ad_sends, pt_sends, fin_cnt, fin_at, ov_cnt, done_cnt, err_cnt, out_bad, viol, key_bad;
  logic prev_dv = 1'b0;
  logic [63:0] exp_q[$];
  logic [127:0] exp_key, exp_nonce;
  bit stall = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] blk(input int row, input int i);
    return {32'hC0DE_0000 + 32'(row), 32'hB10C_0000 + 32'(i)} ^ 64'h5A5A_0F0F_3C3C_9696;
  endfunction

  function automatic logic [127:0] key_of(input int row);
    return {64'hF0E1_D2C3_B4A5_9687 ^ 64'(row), 64'h1122_3344_5566_7788 + 64'(row)};
  endfunction

  function automatic logic [127:0] nonce_of(input int row);
    return {64'hA1B2_C3D4_E5F6_0718 + 64'(row), 64'h0F1E_2D3C_4B5A_6978 ^ 64'(row)};
  endfunction

  task automatic clear_counts();
    init_cnt = 0; ad_sends = 0; pt_sends = 0; fin_cnt = 0; fin_at = 0; ov_cnt = 0;
    done_cnt = 0; err_cnt = 0; out_bad = 0; viol = 0; key_bad = 0;
    exp_q.delete();
  endtask

  // Core model: completion pulses a few cycles after each command
  initial begin
    int pend, pcnt;
    logic [63:0] acc_m, blk_m;
    logic [127:0] mkey, mnonce;
    pend = 0; pcnt = 0; acc_m = 64'd0; blk_m = 64'd0; mkey = 128'd0; mnonce = 128'd0;
    end_initialisation_i = 1'b0; end_associate_i = 1'b0; end_cipher_i = 1'b0;
    cipher_valid_i = 1'b0; end_tag_i = 1'b0; cipher_i = 64'd0; tag_i = 128'd0;
    forever begin
      @(negedge clk);
      end_initialisation_i = 1'b0; end_associate_i = 1'b0; end_cipher_i = 1'b0;
      cipher_valid_i = 1'b0; end_tag_i = 1'b0;
      if (reset_i) begin
        pend = 0; pcnt = 0; acc_m = 64'd0;
      end else begin
        if (pcnt > 0) begin
          pcnt--;
          if (pcnt == 0) begin
            case (pend)
              1: end_initialisation_i = 1'b1;
              2: end_associate_i = 1'b1;
              3: begin cipher_valid_i = 1'b1; cipher_i = blk_m ^ mkey[63:0]; end_cipher_i = !stall; end
              4: begin
                cipher_valid_i = 1'b1; cipher_i = blk_m ^ mkey[63:0]; end_tag_i = 1'b1;
                tag_i = {mnonce[127:64] ^ acc_m, mkey[63:0] ^ acc_m};
              end
              default: ;
            endcase
          end
        end
        if (init_o) begin
          pend = 1; pcnt = 3; acc_m = 64'd0; mkey = key_o; mnonce = nonce_o;
        end else if (data_valid_o) begin
          acc_m ^= data_o; blk_m = data_o; pcnt = 2;
          pend = associate_data_o ? 2 : (finalisation_o ? 4 : 3);
        end
      end
    end
  end

  // Output monitor: event counters and protocol sanity
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset_i) begin
        if (init_o) init_cnt++;
        if ((init_o || data_valid_o) && (key_o !== exp_key || nonce_o !== exp_nonce)) key_bad++;
        if (data_valid_o) begin
          if (associate_data_o) ad_sends++;
          else pt_sends++;
          if (finalisation_o) begin fin_cnt++; fin_at = pt_sends; end
          if (prev_dv) viol++;
        end
        if (finalisation_o && !data_valid_o) viol++;
        if (blk_ready_o && !busy_o) viol++;
        if (out_valid_o) begin
          ov_cnt++;
          if (exp_q.size() == 0) out_bad++;
          else begin
            e = exp_q.pop_front();
            if (out_data_o !== e) out_bad++;
          end
        end
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
      end
      prev_dv = data_valid_o;
    end
  end

  task automatic send_block(input logic [63:0] d, input int hold);
    int t, hold_bad;
    t = 0; hold_bad = 0;
    while (!blk_ready_o && t < 500) begin @(negedge clk); t++; end
    check("blk_ready_wait", 128'(t >= 500), 128'(0));
    if (hold > 0) begin
      start_i = 1'b1; pt_len_i = '0;
      for (int k = 0; k < hold; k++) begin
        if (data_valid_o || err_o) hold_bad++;
        @(negedge clk);
      end
      start_i = 1'b0;
      check("hold_quiet", 128'(hold_bad), 128'(0));
      check("hold_ready", 128'(blk_ready_o), 128'(1));
    end
    blk_data_i = d; blk_valid_i = 1'b1;
    @(negedge clk);
    blk_valid_i = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n;
    n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < max) begin @(negedge clk); n++; end
    check("end_wait", 128'(n >= max), 128'(0));
  endtask

  task automatic run_txn(input vec_t v, input int row);
    logic [127:0] k, nn;
    logic [63:0] acc, b;
    clear_counts();
    stall = 1'b0; acc = 64'd0;
    k = key_of(row); nn = nonce_of(row); exp_key = k; exp_nonce = nn;
    ad_len_i = LEN_W'(v.ad); pt_len_i = LEN_W'(v.pt); key_i = k; nonce_i = nn; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check($sformatf("r%0d start_busy", row), 128'(busy_o), 128'(1));
    check($sformatf("r%0d init_pulse", row), 128'(init_o), 128'(1));
    for (int i = 0; i < v.ad + v.pt; i++) begin
      b = blk(row, i); acc ^= b;
      if (i >= v.ad) exp_q.push_back(b ^ k[63:0]);
      send_block(b, (i == v.hold_idx) ? v.hold_n : 0);
    end
    wait_end(2000);
    repeat (3) @(negedge clk);
    check($sformatf("r%0d init_cnt", row), 128'(init_cnt), 128'(1));
    check($sformatf("r%0d ad_sends", row), 128'(ad_sends), 128'(v.exp_ad));
    check($sformatf("r%0d pt_sends", row), 128'(pt_sends), 128'(v.exp_pt));
    check($sformatf("r%0d fin_cnt", row), 128'(fin_cnt), 128'(1));
    check($sformatf("r%0d fin_at", row), 128'(fin_at), 128'(v.exp_fin_at));
    check($sformatf("r%0d out_valid_cnt", row), 128'(ov_cnt), 128'(v.exp_ov));
    check($sformatf("r%0d out_data", row), 128'(out_bad), 128'(0));
    check($sformatf("r%0d done_cnt", row), 128'(done_cnt), 128'(v.exp_done));
    check($sformatf("r%0d err_cnt", row), 128'(err_cnt), 128'(0));
    check($sformatf("r%0d tag", row), tag_o, {nn[127:64] ^ acc, k[63:0] ^ acc});
    check($sformatf("r%0d protocol", row), 128'(viol), 128'(0));
    check($sformatf("r%0d key_nonce", row), 128'(key_bad), 128'(0));
    check($sformatf("r%0d idle", row), 128'(busy_o), 128'(0));
  endtask

  initial begin
    int n;
    reset_i = 1'b1; start_i = 1'b0; ad_len_i = '0; pt_len_i = '0;
    key_i = 128'd0; nonce_i = 128'd0; blk_data_i = 64'd0; blk_valid_i = 1'b0;
    exp_key = 128'd0; exp_nonce = 128'd0;
    clear_counts();
    vecs[0] = '{1, 22, -1, 0, 1, 22, 22, 22, 1};
    vecs[1] = '{0, 1, -1, 0, 0, 1, 1, 1, 1};
    vecs[2] = '{3, 2, 3, 10, 3, 2, 2, 2, 1};
    vecs[3] = '{31, 31, -1, 0, 31, 31, 31, 31, 1};
    rst_vec = '{1, 2, -1, 0, 1, 2, 2, 2, 1};

    repeat (3) @(negedge clk);
    check("reset_busy", 128'(busy_o), 128'(0));
    check("reset_ready", 128'(blk_ready_o), 128'(0));
    check("reset_tag", tag_o, 128'd0);
    reset_i = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 4; r++) run_txn(vecs[r], r);

    // pt_len = 0 is rejected with a one-cycle error
    clear_counts();
    ad_len_i = 5'd2; pt_len_i = 5'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("zero_pt err", 128'(err_o), 128'(1));
    check("zero_pt busy", 128'(busy_o), 128'(0));
    @(negedge clk);
    check("zero_pt err_width", 128'(err_o), 128'(0));
    repeat (4) @(negedge clk);
    check("zero_pt no_init", 128'(init_cnt), 128'(0));
    check("zero_pt err_cnt", 128'(err_cnt), 128'(1));

    // Core never signals end_cipher_i: timeout after TIMEOUT wait cycles
    clear_counts();
    stall = 1'b1;
    exp_key = key_of(7); exp_nonce = nonce_of(7);
    ad_len_i = 5'd0; pt_len_i = 5'd2; key_i = exp_key; nonce_i = exp_nonce; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    exp_q.push_back(blk(7, 0) ^ exp_key[63:0]);
    send_block(blk(7, 0), 0);
    n = 0;
    while (!err_o && n < 400) begin @(negedge clk); n++; end
    check("timeout cycles", 128'(n), 128'(255));
    check("timeout idle", 128'(busy_o), 128'(0));
    @(negedge clk);
    check("timeout err_width", 128'(err_o), 128'(0));
    check("timeout no_done", 128'(done_cnt), 128'(0));
    check("timeout err_cnt", 128'(err_cnt), 128'(1));
    stall = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in AD_WAIT clears everything at once, then a fresh run completes
    clear_counts();
    exp_key = key_of(9); exp_nonce = nonce_of(9);
    ad_len_i = 5'd2; pt_len_i = 5'd1; key_i = exp_key; nonce_i = exp_nonce; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    send_block(blk(9, 0), 0);
    check("pre_reset assoc", 128'(associate_data_o), 128'(1));
    reset_i = 1'b1;
    #1;
    check("rst busy", 128'(busy_o), 128'(0));
    check("rst data_valid", 128'(data_valid_o), 128'(0));
    check("rst assoc", 128'(associate_data_o), 128'(0));
    check("rst key", key_o, 128'd0);
    check("rst data", 128'(data_o), 128'd0);
    check("rst tag", tag_o, 128'd0);
    check("rst out_data", 128'(out_data_o), 128'd0);
    @(negedge clk);
    reset_i = 1'b0;
    run_txn(rst_vec, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end
endmodule
